// File: rtl/barrel_rotator_arbiter.sv
// barrel_rotator_arbiter: shares one right-rotator between REQUESTERS
// valid/ready clients and returns each result through a one-entry,
// id-tagged output register.
// Optional feature macro: BARREL_ROTATOR_ARBITER_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting at a rotating pointer
//   undefined -> fixed priority, lowest requester index wins

// Purely combinational log-depth right rotator.
module barrel_rotator_right #(
    parameter int WIDTH = 8,
    localparam int WIDTH_LOG2 = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]      data,
    input  logic [WIDTH_LOG2-1:0] rotation,
    output logic [WIDTH-1:0]      result
);
    logic [WIDTH-1:0] stage [WIDTH_LOG2+1];

    assign stage[0] = data;

    // Stage s rotates right by 2**s when rotation bit s is set.
    for (genvar s = 0; s < WIDTH_LOG2; s++) begin : g_stage
        localparam int SHIFT = 1 << s;
        assign stage[s+1] = rotation[s]
            ? {stage[s][SHIFT-1:0], stage[s][WIDTH-1:SHIFT]}
            : stage[s];
    end

    assign result = stage[WIDTH_LOG2];
endmodule

module barrel_rotator_arbiter #(
    parameter int WIDTH      = 8,
    parameter int REQUESTERS = 4,
    localparam int WIDTH_LOG2      = $clog2(WIDTH),
    localparam int REQUESTERS_LOG2 = $clog2(REQUESTERS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            request_valid,
    output logic [REQUESTERS-1:0]            request_ready,
    input  logic [REQUESTERS*WIDTH-1:0]      request_data,
    input  logic [REQUESTERS*WIDTH_LOG2-1:0] request_rotation,
    output logic                             response_valid,
    input  logic                             response_ready,
    output logic [WIDTH-1:0]                 response_data,
    output logic [REQUESTERS_LOG2-1:0]       response_id
);
    logic                       slot_free;
    logic                       grant_any;
    logic                       accept;
    logic [REQUESTERS_LOG2-1:0] winner;
    logic [WIDTH-1:0]           winner_data;
    logic [WIDTH_LOG2-1:0]      winner_rotation;
    logic [WIDTH-1:0]           rotated;

    // The output slot can take a new result if it is empty or draining now.
    assign slot_free = !response_valid || response_ready;
    assign accept    = grant_any && slot_free && !reset;

`ifdef BARREL_ROTATOR_ARBITER_ROUND_ROBIN_EN
    logic [REQUESTERS_LOG2-1:0] pointer;

    // Round-robin search: first valid requester at or above pointer, wrapping.
    always_comb begin
        logic [REQUESTERS_LOG2-1:0] candidate;
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        candidate = '0;
        grant_any = 1'b0;
        winner    = '0;
        for (int offset = 0; offset < REQUESTERS; offset++) begin
            candidate = REQUESTERS_LOG2'((int'(pointer) + offset) % REQUESTERS);
            if (!grant_any && request_valid[candidate]) begin
                grant_any = 1'b1;
                winner    = candidate;
            end
        end
    end

    // Advance the pointer past the winner on each grant; hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer <= '0;
        end else if (accept) begin
            if (winner == REQUESTERS_LOG2'(REQUESTERS - 1)) begin
                pointer <= '0;
            end else begin
                pointer <= winner + 1'b1;
            end
        end
    end
`else
    // Fixed priority: scan downward so the lowest valid index is written last.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (request_valid[i]) begin
                grant_any = 1'b1;
                winner    = REQUESTERS_LOG2'(i);
            end
        end
    end
`endif

    assign request_ready   = accept ? (REQUESTERS'(1) << winner) : '0;
    assign winner_data     = request_data[int'(winner)*WIDTH +: WIDTH];
    assign winner_rotation = request_rotation[int'(winner)*WIDTH_LOG2 +: WIDTH_LOG2];

    barrel_rotator_right #(
        .WIDTH(WIDTH)
    ) u_rotator (
        .data    (winner_data),
        .rotation(winner_rotation),
        .result  (rotated)
    );

    // One-entry output register: refill on grant, empty on drain without refill.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            response_valid <= 1'b0;
            response_data  <= '0;
            response_id    <= '0;
        end else if (accept) begin
            response_valid <= 1'b1;
            response_data  <= rotated;
            response_id    <= winner;
        end else if (slot_free) begin
            response_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_barrel_rotator_arbiter.sv
// Scoreboard bench for barrel_rotator_arbiter: a driver runs a reference
// model (arbitration by search over pending requests, rotation by shift
// arithmetic) and queues expected results; a monitor pops them on every
// response transfer.
module tb_barrel_rotator_arbiter;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int WL = $clog2(W);
    localparam int RL = $clog2(R);

    logic              clock = 1'b0;
    logic              reset;
    logic [R-1:0]      request_valid;
    logic [R-1:0]      request_ready;
    logic [R*W-1:0]    request_data;
    logic [R*WL-1:0]   request_rotation;
    logic              response_valid;
    logic              response_ready;
    logic [W-1:0]      response_data;
    logic [RL-1:0]     response_id;

    barrel_rotator_arbiter #(.WIDTH(W), .REQUESTERS(R)) dut (
        .clock           (clock),
        .reset           (reset),
        .request_valid   (request_valid),
        .request_ready   (request_ready),
        .request_data    (request_data),
        .request_rotation(request_rotation),
        .response_valid  (response_valid),
        .response_ready  (response_ready),
        .response_data   (response_data),
        .response_id     (response_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } resp_t;

    resp_t        exp_q[$];
    int           errors = 0;
    int           checks = 0;

    // Requester-side stimulus state (held until granted).
    logic [R-1:0] pv;
    logic [W-1:0] pd [R];
    int           pr [R];
    logic         rr;

    // Reference model state.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rot_ref(logic [W-1:0] d, int r);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, d};
        wide = (wide >> r) | (wide << (W - r));
        return wide[W-1:0];
    endfunction

    // Winner among pending requesters, or -1 if none.
    function automatic int pick();
        int start;
`ifdef BARREL_ROTATOR_ARBITER_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < R; k++) begin
            if (pv[(start + k) % R]) return (start + k) % R;
        end
        return -1;
    endfunction

    task automatic drive();
        request_valid  = pv;
        response_ready = rr;
        for (int i = 0; i < R; i++) begin
            request_data[i*W +: W]       = pd[i];
            request_rotation[i*WL +: WL] = WL'(pr[i]);
        end
    endtask

    // One clock cycle; entered and left at posedge+2.
    task automatic cycle();
        logic [R-1:0] exp_ready;
        bit           slot_free;
        int           w;
        drive();
        #1;
        slot_free = !m_valid || rr;
        w = slot_free ? pick() : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("request_ready", 32'(request_ready), 32'(exp_ready));
        check("response_valid", 32'(response_valid), 32'(m_valid));
        check("response_data", 32'(response_data), 32'(m_data));
        check("response_id", 32'(response_id), m_id);
        if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = rot_ref(pd[w], pr[w]);
            m_id    = w;
            m_ptr   = (w + 1) % R;
            exp_q.push_back('{w, m_data});
            pv[w] = 1'b0;
        end else if (slot_free) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        drive();
        #1;
        check("ready_in_reset", 32'(request_ready), 32'd0);
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        exp_q.delete();
        repeat (n) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < R; i++) begin
            if (!pv[i]) begin
                pv[i] = 1'b1;
                pd[i] = W'($urandom);
                pr[i] = $urandom_range(0, W - 1);
            end
        end
    endtask

    // Monitor: every response transfer must match the oldest expected result.
    initial begin
        resp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && response_valid === 1'b1 && response_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected at %0t: got id %0d data %0h expected no response",
                             $time, response_id, response_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_id", 32'(response_id), e.id);
                    check("sb_data", 32'(response_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        pv = '0;
        rr = 1'b1;
        for (int i = 0; i < R; i++) begin
            pd[i] = '0;
            pr[i] = 0;
        end
        reset = 1'b1;
        drive();
        @(posedge clock);
        #2;
        do_reset(2);

        // Single request from requester 1.
        pv[1] = 1'b1; pd[1] = 8'b10011001; pr[1] = 3;
        repeat (3) cycle();

        // Rotation sweep, back to back from requester 0.
        for (int r = 0; r < W; r++) begin
            pv[0] = 1'b1; pd[0] = 8'b10011001; pr[0] = r;
            cycle();
        end
        repeat (2) cycle();

        // Contention: every requester always valid.
        repeat (8) begin
            fill_all();
            cycle();
        end

        // Backpressure with results pending, then release.
        fill_all();
        rr = 1'b0;
        repeat (3) cycle();
        rr = 1'b1;
        repeat (2) cycle();

        // Reset while a result is held and requests are pending.
        fill_all();
        rr = 1'b0;
        cycle();
        fill_all();
        do_reset(1);
        rr = 1'b1;
        repeat (R + 2) cycle();

        // Sparse: only requester 2, then only requester 0.
        pv[2] = 1'b1; pd[2] = W'($urandom); pr[2] = 5;
        repeat (2) cycle();
        pv[0] = 1'b1; pd[0] = W'($urandom); pr[0] = 1;
        repeat (2) cycle();
        // After those grants the pointer sits at 1, so 1 beats 0 (round-robin only).
        pv[0] = 1'b1; pd[0] = W'($urandom); pr[0] = 2;
        pv[1] = 1'b1; pd[1] = W'($urandom); pr[1] = 6;
        repeat (3) cycle();

        // Randomized traffic with random backpressure and occasional reset.
        repeat (400) begin
            for (int i = 0; i < R; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 40) begin
                    pv[i] = 1'b1;
                    pd[i] = W'($urandom);
                    pr[i] = $urandom_range(0, W - 1);
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset(1);
            else cycle();
        end

        // Drain everything still pending.
        rr = 1'b1;
        repeat (R + 3) cycle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
